// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous BRAM between two requesters.
// Port A has fixed priority. A saturating starvation counter forces a port-B grant
// once B has lost STARVE_LIMIT consecutive contended cycles. Read ownership is
// tracked for one cycle so the returning BRAM data is steered to the right port.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH   = 14,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   // port A (pipeline side, high priority)
   input  logic                  a_valid,
   input  logic                  a_write,
   input  logic [3:0]            a_wmask,
   input  logic [31:0]           a_wdata,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   output logic                  a_ready,
   output logic                  a_rvalid,
   output logic [31:0]           a_rdata,
   // port B (secondary master)
   input  logic                  b_valid,
   input  logic                  b_write,
   input  logic [3:0]            b_wmask,
   input  logic [31:0]           b_wdata,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   output logic                  b_ready,
   output logic                  b_rvalid,
   output logic [31:0]           b_rdata,
   // BRAM side
   output logic                  mem_write,
   output logic [3:0]            mem_wmask,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [31:0]           mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_q, starve_d;
   logic       rsel_a_q, rsel_a_d;
   logic       rsel_b_q, rsel_b_d;
   logic       grant_a, grant_b;

   // Arbitration: B wins when alone or starved; grants are held off during reset
   // so nothing reaches the BRAM while rstn is low.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (rstn) begin
         if (b_valid && (!a_valid || starve_q == LIMIT)) grant_b = 1'b1;
         else if (a_valid)                                grant_a = 1'b1;
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // Memory mux: the winner drives the BRAM; port A is the idle default.
   always_comb begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
      mem_wmask = a_wmask;
      mem_write = grant_a & a_write;
      if (grant_b) begin
         mem_addr  = b_addr;
         mem_wdata = b_wdata;
         mem_wmask = b_wmask;
         mem_write = b_write;
      end
   end

   // Next state: starvation count and read-return ownership for the next cycle.
   always_comb begin
      starve_d = starve_q;
      if (!b_valid || grant_b)  starve_d = 4'd0;
      else if (starve_q < LIMIT) starve_d = starve_q + 4'd1;
      rsel_a_d = grant_a & ~a_write;
      rsel_b_d = grant_b & ~b_write;
   end

   // State registers; async reset drops any pending read return.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         starve_q <= 4'd0;
         rsel_a_q <= 1'b0;
         rsel_b_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         rsel_a_q <= rsel_a_d;
         rsel_b_q <= rsel_b_d;
      end
   end

   // Read return: BRAM data goes only to the owning port, the other sees 0.
   assign a_rvalid = rsel_a_q;
   assign b_rvalid = rsel_b_q;
   assign a_rdata  = rsel_a_q ? mem_rdata : 32'd0;
   assign b_rdata  = rsel_b_q ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances share the same stimulus:
// d0 with STARVE_LIMIT=4 and d1 with STARVE_LIMIT=1, each with its own
// read-before-write BRAM model with byte enables.
module tb_mem_port_arbiter;

   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rstn;
   logic          a_valid, a_write, b_valid, b_write;
   logic [3:0]    a_wmask, b_wmask;
   logic [31:0]   a_wdata, b_wdata;
   logic [AW-1:0] a_addr, b_addr;

   logic          d0_a_ready, d0_a_rvalid, d0_b_ready, d0_b_rvalid, d0_mem_write;
   logic [31:0]   d0_a_rdata, d0_b_rdata, d0_mem_wdata, d0_mem_rdata;
   logic [3:0]    d0_mem_wmask;
   logic [AW-1:0] d0_mem_addr;

   logic          d1_a_ready, d1_a_rvalid, d1_b_ready, d1_b_rvalid, d1_mem_write;
   logic [31:0]   d1_a_rdata, d1_b_rdata, d1_mem_wdata, d1_mem_rdata;
   logic [3:0]    d1_mem_wmask;
   logic [AW-1:0] d1_mem_addr;

   logic [31:0] mem0 [0:(1<<AW)-1];
   logic [31:0] mem1 [0:(1<<AW)-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(4)) d0 (
      .clk(clk), .rstn(rstn),
      .a_valid(a_valid), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
      .a_ready(d0_a_ready), .a_rvalid(d0_a_rvalid), .a_rdata(d0_a_rdata),
      .b_valid(b_valid), .b_write(b_write), .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
      .b_ready(d0_b_ready), .b_rvalid(d0_b_rvalid), .b_rdata(d0_b_rdata),
      .mem_write(d0_mem_write), .mem_wmask(d0_mem_wmask), .mem_wdata(d0_mem_wdata),
      .mem_addr(d0_mem_addr), .mem_rdata(d0_mem_rdata)
   );

   mem_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(1)) d1 (
      .clk(clk), .rstn(rstn),
      .a_valid(a_valid), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
      .a_ready(d1_a_ready), .a_rvalid(d1_a_rvalid), .a_rdata(d1_a_rdata),
      .b_valid(b_valid), .b_write(b_write), .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
      .b_ready(d1_b_ready), .b_rvalid(d1_b_rvalid), .b_rdata(d1_b_rdata),
      .mem_write(d1_mem_write), .mem_wmask(d1_mem_wmask), .mem_wdata(d1_mem_wdata),
      .mem_addr(d1_mem_addr), .mem_rdata(d1_mem_rdata)
   );

   // BRAM models: synchronous read of the old word, byte-masked write.
   always @(posedge clk) begin
      d0_mem_rdata <= mem0[d0_mem_addr];
      d1_mem_rdata <= mem1[d1_mem_addr];
      if (d0_mem_write)
         for (int i = 0; i < 4; i++)
            if (d0_mem_wmask[i]) mem0[d0_mem_addr][8*i +: 8] <= d0_mem_wdata[8*i +: 8];
      if (d1_mem_write)
         for (int j = 0; j < 4; j++)
            if (d1_mem_wmask[j]) mem1[d1_mem_addr][8*j +: 8] <= d1_mem_wdata[8*j +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      a_valid = 0; a_write = 0; a_wmask = 0; a_wdata = 0;
      b_valid = 0; b_write = 0; b_wmask = 0; b_wdata = 0;
   endtask

   initial begin
      logic expb, prevb;
      for (int k = 0; k < (1<<AW); k++) begin mem0[k] = 32'h0; mem1[k] = 32'h0; end
      mem0[14'h3F80] = 32'h00000013; mem1[14'h3F80] = 32'h00000013;
      mem0[14'h0010] = 32'h11223344; mem1[14'h0010] = 32'h11223344;
      mem0[14'h0020] = 32'h00000055; mem1[14'h0020] = 32'h00000055;

      // Reset: requests present but nothing granted or written.
      rstn = 0; idle();
      a_addr = 14'h3F80; b_addr = 14'h0010;
      a_valid = 1; b_valid = 1; b_write = 1; b_wmask = 4'hF;
      smp();
      chk("rst_a_ready",  32'(d0_a_ready), 0);
      chk("rst_b_ready",  32'(d0_b_ready), 0);
      chk("rst_a_rvalid", 32'(d0_a_rvalid), 0);
      chk("rst_b_rvalid", 32'(d0_b_rvalid), 0);
      chk("rst_a_rdata",  d0_a_rdata, 0);
      chk("rst_b_rdata",  d0_b_rdata, 0);
      chk("rst_mem_write", 32'(d0_mem_write), 0);
      nxt(); idle(); rstn = 1;
      smp();
      chk("idle_mem_addr_from_a", 32'(d0_mem_addr), 32'h3F80);

      // 1. A-only read.
      nxt(); a_valid = 1; a_addr = 14'h3F80;
      smp();
      chk("t1_a_ready", 32'(d0_a_ready), 1);
      chk("t1_b_ready", 32'(d0_b_ready), 0);
      nxt(); a_valid = 0;
      smp();
      chk("t1_a_rvalid", 32'(d0_a_rvalid), 1);
      chk("t1_a_rdata",  d0_a_rdata, 32'h00000013);
      chk("t1_b_rvalid", 32'(d0_b_rvalid), 0);
      chk("t1_b_rdata",  d0_b_rdata, 0);
      nxt();
      smp();
      chk("t1_a_rvalid_pulse", 32'(d0_a_rvalid), 0);

      // 2. B masked write then B read.
      nxt(); b_valid = 1; b_write = 1; b_addr = 14'h0010; b_wmask = 4'b0101; b_wdata = 32'hAABBCCDD;
      smp();
      chk("t2_b_ready",   32'(d0_b_ready), 1);
      chk("t2_mem_write", 32'(d0_mem_write), 1);
      chk("t2_mem_addr",  32'(d0_mem_addr), 32'h0010);
      chk("t2_mem_wdata", d0_mem_wdata, 32'hAABBCCDD);
      nxt(); b_write = 0;
      smp();
      chk("t2_write_no_rvalid", 32'(d0_b_rvalid), 0);
      nxt(); b_valid = 0;
      smp();
      chk("t2_b_rvalid", 32'(d0_b_rvalid), 1);
      chk("t2_b_rdata",  d0_b_rdata, 32'h11BB33DD);
      chk("t2_a_rvalid", 32'(d0_a_rvalid), 0);

      // 3. Continuous contention, STARVE_LIMIT=4: A,A,A,A,B repeating.
      nxt(); idle();
      a_valid = 1; a_addr = 14'h3F80; b_valid = 1; b_addr = 14'h0010;
      prevb = 0;
      for (int i = 0; i < 10; i++) begin
         smp();
         expb = (i % 5 == 4);
         chk($sformatf("t3_a_ready_%0d", i), 32'(d0_a_ready), 32'(!expb));
         chk($sformatf("t3_b_ready_%0d", i), 32'(d0_b_ready), 32'(expb));
         chk($sformatf("t3_mem_addr_%0d", i), 32'(d0_mem_addr), expb ? 32'h0010 : 32'h3F80);
         if (i > 0) begin
            chk($sformatf("t3_a_rvalid_%0d", i), 32'(d0_a_rvalid), 32'(!prevb));
            chk($sformatf("t3_b_rvalid_%0d", i), 32'(d0_b_rvalid), 32'(prevb));
            chk($sformatf("t3_a_rdata_%0d", i), d0_a_rdata, prevb ? 32'h0 : 32'h00000013);
            chk($sformatf("t3_b_rdata_%0d", i), d0_b_rdata, prevb ? 32'h11BB33DD : 32'h0);
         end
         prevb = expb;
         nxt();
      end
      idle();
      smp();
      chk("t3_last_b_rvalid", 32'(d0_b_rvalid), 1);
      chk("t3_last_a_rvalid", 32'(d0_a_rvalid), 0);

      // 4. STARVE_LIMIT=1 instance: strict alternation starting with A.
      nxt();
      a_valid = 1; a_addr = 14'h3F80; b_valid = 1; b_addr = 14'h0010;
      prevb = 0;
      for (int i = 0; i < 6; i++) begin
         smp();
         expb = (i % 2 == 1);
         chk($sformatf("t4_a_ready_%0d", i), 32'(d1_a_ready), 32'(!expb));
         chk($sformatf("t4_b_ready_%0d", i), 32'(d1_b_ready), 32'(expb));
         if (i > 0) begin
            chk($sformatf("t4_a_rvalid_%0d", i), 32'(d1_a_rvalid), 32'(!prevb));
            chk($sformatf("t4_b_rvalid_%0d", i), 32'(d1_b_rvalid), 32'(prevb));
            chk($sformatf("t4_rdata_%0d", i), prevb ? d1_b_rdata : d1_a_rdata,
                prevb ? 32'h11BB33DD : 32'h00000013);
         end
         prevb = expb;
         nxt();
      end
      idle();

      // 5. Reset right after a granted read: return dropped, no write during reset.
      nxt(); a_valid = 1; a_addr = 14'h3F80;
      smp();
      chk("t5_a_ready", 32'(d0_a_ready), 1);
      nxt();
      rstn = 0;
      b_valid = 1; b_write = 1; b_addr = 14'h0020; b_wmask = 4'hF; b_wdata = 32'hFFFFFFFF;
      smp();
      chk("t5_rst_a_rvalid", 32'(d0_a_rvalid), 0);
      chk("t5_rst_a_rdata",  d0_a_rdata, 0);
      chk("t5_rst_a_ready",  32'(d0_a_ready), 0);
      chk("t5_rst_b_ready",  32'(d0_b_ready), 0);
      chk("t5_rst_mem_write", 32'(d0_mem_write), 0);
      nxt(); nxt();
      idle(); rstn = 1;
      smp();
      chk("t5_rel_a_rvalid", 32'(d0_a_rvalid), 0);
      chk("t5_rel_b_rvalid", 32'(d0_b_rvalid), 0);
      nxt();
      smp();
      chk("t5_rel2_a_rvalid", 32'(d0_a_rvalid), 0);
      nxt(); a_valid = 1; a_addr = 14'h0020;
      smp();
      nxt(); a_valid = 0;
      smp();
      chk("t5_no_write_rvalid", 32'(d0_a_rvalid), 1);
      chk("t5_no_write_data",   d0_a_rdata, 32'h00000055);

      // 6. Back-to-back A read then B read.
      nxt(); a_valid = 1; a_addr = 14'h3F80;
      smp();
      chk("t6_a_ready", 32'(d0_a_ready), 1);
      nxt(); a_valid = 0; b_valid = 1; b_addr = 14'h0010;
      smp();
      chk("t6_b_ready",  32'(d0_b_ready), 1);
      chk("t6_a_rvalid", 32'(d0_a_rvalid), 1);
      chk("t6_a_rdata",  d0_a_rdata, 32'h00000013);
      chk("t6_b_rvalid_early", 32'(d0_b_rvalid), 0);
      nxt(); b_valid = 0;
      smp();
      chk("t6_b_rvalid", 32'(d0_b_rvalid), 1);
      chk("t6_b_rdata",  d0_b_rdata, 32'h11BB33DD);
      chk("t6_a_rvalid_late", 32'(d0_a_rvalid), 0);
      nxt();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
